sys_feeder: RTL and testbench

//  Input stage feeding the systolic array, directly upstream of the array and steered by sys_ctrl.

---
 rtl/sys_feeder_if.sv | 32 +++
 rtl/sys_feeder.sv | 159 +++++++++++++++
 tb/tb_sys_feeder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sys_feeder_if.sv
// Purpose : bundles the feeder's upstream vector handshake and its array-facing outputs.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready handshake upstream; array-side outputs are never stalled.
// Ports (slave = feeder side):
//   ctrl_in, in_valid, in_data           -> feeder
//   in_ready, w_data, w_shift, a_data,
//   a_valid, busy, err                   <- feeder
interface sys_feeder_if #(
  parameter int ROWS = 4,
  parameter int DW   = 8
) ();
  logic                 ctrl_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic [ROWS*DW-1:0]   w_data;
  logic                 w_shift;
  logic [ROWS*DW-1:0]   a_data;
  logic [ROWS-1:0]      a_valid;
  logic                 busy;
  logic                 err;

  modport slave (
    input  ctrl_in, in_valid, in_data,
    output in_ready, w_data, w_shift, a_data, a_valid, busy, err
  );

  modport master (
    output ctrl_in, in_valid, in_data,
    input  in_ready, w_data, w_shift, a_data, a_valid, busy, err
  );
endinterface

// File: rtl/sys_feeder.sv
// Purpose : systolic-array input stage; loads ROWS weight vectors, then streams skewed activations.
// Latency : weight beat -> w_shift 1 cycle; activation lane r -> row r after 1+r cycles.
// Backpressure: in_ready low in IDLE/FLUSH and once ROWS weights are held; never stalls in STREAM.
// Ports:
//   clk, rst (sync, active-low)
//   bus (sys_feeder_if.slave): ctrl_in/in_valid/in_data in; in_ready, w_data, w_shift,
//                              a_data, a_valid, busy, err out
module sys_feeder #(
  parameter int ROWS = 4,
  parameter int DW   = 8
) (
  input  logic         clk,
  input  logic         rst,
  sys_feeder_if.slave  bus
);

  localparam int WW = $clog2(ROWS + 1);
  localparam int FW = $clog2(ROWS);
  localparam logic [WW-1:0] WCNT_FULL = WW'(ROWS);
  localparam logic [FW-1:0] FCNT_LAST = FW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    STREAM = 2'b10,
    FLUSH  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WW-1:0]      r_wcnt;
  logic [WW-1:0]      w_wcnt_nxt;
  logic [WW-1:0]      w_wcnt_inc;
  logic [FW-1:0]      r_fcnt;
  logic [FW-1:0]      w_fcnt_nxt;
  logic               r_err;
  logic               w_err_set;
  logic               w_in_ready;
  logic               w_beat;
  logic               w_load_beat;
  logic               w_stream_beat;
  logic [ROWS*DW-1:0] r_w_data;
  logic               r_w_shift;

  // ---------------- FSM: output decode ----------------
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      LOAD:    w_in_ready = (r_wcnt < WCNT_FULL);
      STREAM:  w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_beat        = bus.in_valid & w_in_ready;
  assign w_load_beat   = w_beat & (r_state == LOAD);
  assign w_stream_beat = w_beat & (r_state == STREAM);
  // Post-increment count: a beat landing on the same edge as ctrl_in falling still counts.
  assign w_wcnt_inc    = r_wcnt + WW'(w_load_beat);

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_fcnt_nxt  = r_fcnt;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ctrl_in) begin
          w_state_nxt = LOAD;
          w_wcnt_nxt  = '0;
        end else begin
          w_state_nxt = STREAM;
        end
      end
      LOAD: begin
        w_wcnt_nxt = w_wcnt_inc;
        if (!bus.ctrl_in) begin
          w_state_nxt = STREAM;
          w_err_set   = (w_wcnt_inc < WCNT_FULL);
        end
      end
      STREAM: begin
        if (bus.ctrl_in) begin
          w_state_nxt = FLUSH;
          w_fcnt_nxt  = '0;
        end
      end
      FLUSH: begin
        // Last activation leaves row ROWS-1 on the cycle fcnt hits ROWS-1.
        if (r_fcnt == FCNT_LAST) begin
          if (bus.ctrl_in) begin
            w_state_nxt = LOAD;
            w_wcnt_nxt  = '0;
          end else begin
            w_state_nxt = STREAM;
          end
        end else begin
          w_fcnt_nxt = r_fcnt + FW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // ---------------- weight path ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w_data  <= '0;
      r_w_shift <= 1'b0;
    end else begin
      r_w_shift <= w_load_beat;
      if (w_load_beat) r_w_data <= bus.in_data;
    end
  end

  // ---------------- activation skew ----------------
  // Row r is a (r+1)-deep shift line; non-beat cycles enter as zero-data bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] r_dat [r+1];
    logic [r:0]    r_vld;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_vld <= '0;
        for (int k = 0; k <= r; k++) r_dat[k] <= '0;
      end else begin
        r_vld    <= (r_vld << 1) | (r + 1)'(w_stream_beat);
        r_dat[0] <= w_stream_beat ? bus.in_data[r*DW +: DW] : '0;
        for (int k = 1; k <= r; k++) r_dat[k] <= r_dat[k-1];
      end
    end

    assign bus.a_valid[r]           = r_vld[r];
    assign bus.a_data[r*DW +: DW]   = r_dat[r];
  end

  assign bus.in_ready = w_in_ready;
  assign bus.w_data   = r_w_data;
  assign bus.w_shift  = r_w_shift;
  assign bus.busy     = (r_state != IDLE);
  assign bus.err      = r_err;

endmodule

// File: tb/tb_sys_feeder.sv
// Purpose : self-checking bench for sys_feeder with a queue scoreboard and decoupled monitor.
// Latency : expected entries carry the cycle they must appear on (weight t+1, row r t+1+r).
// Backpressure: stimulus states the in_ready it expects; only expected beats are scoreboarded.
module tb_sys_feeder;
  localparam int ROWS = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [63:0] w_q[$];
  logic [63:0] a_q[ROWS][$];

  sys_feeder_if #(.ROWS(ROWS), .DW(DW)) bus ();

  sys_feeder #(.ROWS(ROWS), .DW(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [31:0] d);
    w_q.push_back({32'(cyc + 1), d});
  endtask

  task automatic push_a(input logic [31:0] d);
    for (int r = 0; r < ROWS; r++)
      a_q[r].push_back({32'(cyc + 1 + r), 24'd0, d[r*DW +: DW]});
  endtask

  // One LOAD-phase cycle: offer a vector, check readiness, expect a shift if accepted.
  task automatic load_w(input logic [31:0] d, input logic exp_rdy);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    chk("in_ready_load", bus.in_ready, exp_rdy);
    if (exp_rdy) push_w(d);
    step();
  endtask

  // One STREAM-phase cycle: beat (v=1) or bubble (v=0).
  task automatic stream_a(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    chk("in_ready_stream", bus.in_ready, 1'b1);
    if (v) push_a(d);
    step();
  endtask

  // Monitor: pops expectations whenever the DUT presents weights or activations.
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.w_shift === 1'b1) begin
      chk("w_overlap_a", 64'(|bus.a_valid), 64'd0);
      if (w_q.size() == 0) begin
        chk("w_shift_unexpected", bus.w_shift, 1'b0);
      end else begin
        e = w_q.pop_front();
        chk("w_data", bus.w_data, e[31:0]);
        chk("w_cycle", 64'(cyc), e[63:32]);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (bus.a_valid[r] === 1'b1) begin
        if (a_q[r].size() == 0) begin
          chk("a_valid_unexpected", bus.a_valid[r], 1'b0);
        end else begin
          e = a_q[r].pop_front();
          chk($sformatf("a_data_row%0d", r), bus.a_data[r*DW +: DW], e[DW-1:0]);
          chk($sformatf("a_cycle_row%0d", r), 64'(cyc), e[63:32]);
        end
      end
    end
  end

  initial begin
    int stale;
    // 1. reset with active-looking inputs
    rst          = 1'b0;
    bus.ctrl_in  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hdeadbeef;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_w_shift",  bus.w_shift,  1'b0);
    chk("rst_a_valid",  bus.a_valid,  4'd0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_err",      bus.err,      1'b0);

    // 2. full weight load
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    step();                                   // IDLE -> LOAD
    chk("busy_load", bus.busy, 1'b1);
    for (int i = 1; i <= ROWS; i++) load_w({4{8'(i)}}, 1'b1);
    load_w(32'h05050505, 1'b0);               // fifth vector held
    bus.ctrl_in  = 1'b0;
    bus.in_valid = 1'b0;
    step();                                   // LOAD -> STREAM
    chk("err_full_load", bus.err, 1'b0);

    // 4. skewed stream with a bubble
    stream_a(1'b1, 32'h40302010);
    stream_a(1'b0, 32'h99999999);
    stream_a(1'b1, 32'h44332211);
    stream_a(1'b0, 32'h00000000);

    // 5. raise ctrl_in with a beat on the same cycle, then flush
    bus.ctrl_in = 1'b1;
    stream_a(1'b1, 32'h88776655);
    for (int i = 0; i < ROWS; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hffffffff;
      chk("in_ready_flush", bus.in_ready, 1'b0);
      chk("busy_flush",     bus.busy,     1'b1);
      step();
    end

    // 3. short load -> sticky err
    load_w(32'ha1a2a3a4, 1'b1);
    load_w(32'hb1b2b3b4, 1'b1);
    bus.ctrl_in  = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("err_short_load", bus.err, 1'b1);
    stream_a(1'b1, 32'h0c0b0a09);
    stream_a(1'b1, 32'h1c1b1a19);
    chk("err_sticky", bus.err, 1'b1);
    stream_a(1'b1, 32'h2c2b2a29);
    stream_a(1'b1, 32'h3c3b3a39);

    // 6. reset with the skew pipe full
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h5a5a5a5a;
    step();
    chk("midrst_a_valid",  bus.a_valid,  4'd0);
    chk("midrst_busy",     bus.busy,     1'b0);
    chk("midrst_err",      bus.err,      1'b0);
    chk("midrst_w_shift",  bus.w_shift,  1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    stale = 0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < a_q[r].size(); k++)
        if (int'(a_q[r][k][63:32]) < cyc) stale++;
    chk("stale_before_rst", 64'(stale), 64'd0);
    for (int r = 0; r < ROWS; r++) a_q[r].delete();

    // recovery: 4th weight arrives on the same edge ctrl_in falls
    rst          = 1'b1;
    bus.ctrl_in  = 1'b1;
    bus.in_valid = 1'b0;
    step();
    load_w(32'h11111111, 1'b1);
    load_w(32'h22222222, 1'b1);
    load_w(32'h33333333, 1'b1);
    bus.ctrl_in = 1'b0;
    load_w(32'h44444444, 1'b1);
    bus.in_valid = 1'b0;
    chk("err_beat_on_fall", bus.err,      1'b0);
    chk("in_ready_recover", bus.in_ready, 1'b1);
    stream_a(1'b1, 32'h13121110);
    bus.ctrl_in = 1'b1;
    stream_a(1'b0, 32'h00000000);
    bus.in_valid = 1'b0;
    repeat (6) step();

    chk("w_q_drained", 64'(w_q.size()), 64'd0);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("a_q_row%0d_drained", r), 64'(a_q[r].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
